// File: rtl/ddr_axi_burst_bridge.sv
// AXI3 slave front end that splits INCR bursts into single-beat backend commands.
// Read returns are buffered in a credit-limited FIFO so RREADY backpressure never drops data.
module ddr_axi_burst_bridge #(
   parameter int unsigned ADDR_W        = 32,
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned ID_W          = 4,
   parameter int unsigned RD_FIFO_DEPTH = 8
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic [ID_W-1:0]     S_AWID,
   input  logic [ADDR_W-1:0]   S_AWADDR,
   input  logic [3:0]          S_AWLEN,
   input  logic [1:0]          S_AWBURST,
   input  logic                S_AWVALID,
   output logic                S_AWREADY,
   input  logic [DATA_W-1:0]   S_WDATA,
   input  logic [DATA_W/8-1:0] S_WSTRB,
   input  logic                S_WLAST,
   input  logic                S_WVALID,
   output logic                S_WREADY,
   output logic [ID_W-1:0]     S_BID,
   output logic [1:0]          S_BRESP,
   output logic                S_BVALID,
   input  logic                S_BREADY,
   input  logic [ID_W-1:0]     S_ARID,
   input  logic [ADDR_W-1:0]   S_ARADDR,
   input  logic [3:0]          S_ARLEN,
   input  logic [1:0]          S_ARBURST,
   input  logic                S_ARVALID,
   output logic                S_ARREADY,
   output logic [ID_W-1:0]     S_RID,
   output logic [DATA_W-1:0]   S_RDATA,
   output logic [1:0]          S_RRESP,
   output logic                S_RLAST,
   output logic                S_RVALID,
   input  logic                S_RREADY,
   output logic                cmd_valid,
   input  logic                cmd_ready,
   output logic                cmd_write,
   output logic [ADDR_W-1:0]   cmd_addr,
   output logic [DATA_W-1:0]   cmd_wdata,
   output logic [DATA_W/8-1:0] cmd_wstrb,
   input  logic                rd_valid,
   input  logic [DATA_W-1:0]   rd_data
);

   localparam int unsigned SHIFT = $clog2(DATA_W / 8);
   localparam int unsigned PTR_W = $clog2(RD_FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned SUM_W = CNT_W + 1;

   typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD} state_t;

   state_t              r_state;
   logic                r_prio_wr;
   logic [ID_W-1:0]     r_id;
   logic [ADDR_W-1:0]   r_addr;
   logic [3:0]          r_len;
   logic                r_err;
   logic                r_werr;
   logic [4:0]          r_cnt;
   logic [3:0]          r_rbeat;
   logic                r_bvalid;
   logic [1:0]          r_bresp;
   logic [CNT_W-1:0]    r_outstanding;
   logic [CNT_W-1:0]    r_count;
   logic [PTR_W-1:0]    r_wptr;
   logic [PTR_W-1:0]    r_rptr;
   logic [DATA_W-1:0]   r_mem [RD_FIFO_DEPTH];

   logic w_idle, w_aw_grant, w_ar_grant, w_wbeat_last, w_wlast_bad, w_w_hs;
   logic w_fifo_empty, w_credit, w_rd_issue, w_cmd_rd_hs, w_r_hs, w_pop;

   assign w_idle     = (r_state == IDLE);
   assign w_aw_grant = w_idle & S_AWVALID & (~S_ARVALID | r_prio_wr);
   assign w_ar_grant = w_idle & S_ARVALID & (~S_AWVALID | ~r_prio_wr);
   assign S_AWREADY  = w_aw_grant;
   assign S_ARREADY  = w_ar_grant;

   assign w_wbeat_last = (r_cnt == {1'b0, r_len});
   assign w_wlast_bad  = S_WLAST ^ w_wbeat_last;
   assign S_WREADY     = (r_state == WR_DATA) & (cmd_ready | r_err);
   assign w_w_hs       = S_WVALID & S_WREADY;

   // Credit: never have more reads in flight or buffered than the FIFO can hold.
   assign w_fifo_empty = (r_count == '0);
   assign w_credit     = ({1'b0, r_outstanding} + {1'b0, r_count}) < SUM_W'(RD_FIFO_DEPTH);
   assign w_rd_issue   = (r_state == RD) & ~r_err & (r_cnt <= {1'b0, r_len}) & w_credit;
   assign w_cmd_rd_hs  = w_rd_issue & cmd_ready;

   assign cmd_valid = ((r_state == WR_DATA) & S_WVALID & ~r_err) | w_rd_issue;
   assign cmd_write = (r_state == WR_DATA);
   assign cmd_addr  = r_addr + (ADDR_W'(r_cnt) << SHIFT);
   assign cmd_wdata = S_WDATA;
   assign cmd_wstrb = S_WSTRB;

   assign S_RVALID = (r_state == RD) & (r_err | ~w_fifo_empty);
   assign w_r_hs   = S_RVALID & S_RREADY;
   assign w_pop    = w_r_hs & ~r_err;
   assign S_RDATA  = (S_RVALID & ~r_err) ? r_mem[r_rptr] : '0;
   assign S_RRESP  = (S_RVALID & r_err) ? 2'b10 : 2'b00;
   assign S_RLAST  = S_RVALID & (r_rbeat == r_len);
   assign S_RID    = r_id;
   assign S_BID    = r_id;
   assign S_BVALID = r_bvalid;
   assign S_BRESP  = r_bresp;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_state   <= IDLE;
         r_prio_wr <= 1'b1;
         r_id      <= '0;
         r_addr    <= '0;
         r_len     <= '0;
         r_err     <= 1'b0;
         r_werr    <= 1'b0;
         r_cnt     <= '0;
         r_rbeat   <= '0;
         r_bvalid  <= 1'b0;
         r_bresp   <= 2'b00;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_aw_grant) begin
                  r_id      <= S_AWID;
                  r_addr    <= S_AWADDR;
                  r_len     <= S_AWLEN;
                  r_err     <= (S_AWBURST != 2'b01);
                  r_werr    <= 1'b0;
                  r_cnt     <= '0;
                  r_prio_wr <= ~r_prio_wr;
                  r_state   <= WR_DATA;
               end else if (w_ar_grant) begin
                  r_id      <= S_ARID;
                  r_addr    <= S_ARADDR;
                  r_len     <= S_ARLEN;
                  r_err     <= (S_ARBURST != 2'b01);
                  r_cnt     <= '0;
                  r_rbeat   <= '0;
                  r_prio_wr <= ~r_prio_wr;
                  r_state   <= RD;
               end
            end
            WR_DATA: begin
               if (w_w_hs) begin
                  r_cnt <= r_cnt + 5'd1;
                  if (w_wlast_bad) r_werr <= 1'b1;
                  if (w_wbeat_last) begin
                     r_bvalid <= 1'b1;
                     r_bresp  <= (r_err | r_werr | w_wlast_bad) ? 2'b10 : 2'b00;
                     r_state  <= WR_RESP;
                  end
               end
            end
            WR_RESP: begin
               if (S_BREADY) begin
                  r_bvalid <= 1'b0;
                  r_state  <= IDLE;
               end
            end
            RD: begin
               if (w_cmd_rd_hs) r_cnt <= r_cnt + 5'd1;
               if (w_r_hs) begin
                  r_rbeat <= r_rbeat + 4'd1;
                  if (S_RLAST) r_state <= IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_outstanding <= '0;
         r_count       <= '0;
         r_wptr        <= '0;
         r_rptr        <= '0;
      end else begin
         unique case ({w_cmd_rd_hs, rd_valid})
            2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
            2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
            default: r_outstanding <= r_outstanding;
         endcase
         unique case ({rd_valid, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (rd_valid) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)    r_rptr <= r_rptr + PTR_W'(1);
      end
   end

   always_ff @(posedge ACLK) begin
      if (rd_valid) r_mem[r_wptr] <= rd_data;
   end

endmodule

// File: tb/tb_ddr_axi_burst_bridge.sv
// Scoreboard bench for ddr_axi_burst_bridge: expected commands, R beats and B responses are queued
// at grant time and popped as the DUT produces them; the backend model answers reads from the address.
module tb_ddr_axi_burst_bridge;

   localparam int TMO = 300;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } cmd_t;
   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } rexp_t;
   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } bexp_t;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic [3:0]  S_AWID, S_ARID, S_BID, S_RID;
   logic [31:0] S_AWADDR, S_ARADDR, S_WDATA, S_RDATA;
   logic [3:0]  S_AWLEN, S_ARLEN, S_WSTRB;
   logic [1:0]  S_AWBURST, S_ARBURST, S_BRESP, S_RRESP;
   logic        S_AWVALID, S_AWREADY, S_WLAST, S_WVALID, S_WREADY, S_BVALID, S_BREADY;
   logic        S_ARVALID, S_ARREADY, S_RLAST, S_RVALID, S_RREADY;
   logic        cmd_valid, cmd_ready, cmd_write, rd_valid;
   logic [31:0] cmd_addr, cmd_wdata, rd_data;
   logic [3:0]  cmd_wstrb;

   ddr_axi_burst_bridge #(
      .ADDR_W(32), .DATA_W(32), .ID_W(4), .RD_FIFO_DEPTH(8)
   ) u_dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWBURST(S_AWBURST),
      .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
      .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST),
      .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
      .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
      .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARBURST(S_ARBURST),
      .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
      .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
      .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rd_valid(rd_valid), .rd_data(rd_data)
   );

   always #5 ACLK = ~ACLK;

   cmd_t        exp_cmd[$];
   rexp_t       exp_r[$];
   bexp_t       exp_b[$];
   logic [31:0] be_q[$];
   int          n_checks = 0, n_pass = 0;
   int          r_seen = 0, b_seen = 0, rd_returned = 0;
   int          rd_issued = 0, r_popped = 0, wr_issued = 0, occ = 0, max_occ = 0;
   int          n_grants = 0;
   logic [3:0]  glog = '0;
   logic [31:0] last_wr_addr = '0;
   bit          be_toggle = 1'b0;
   cmd_t        m_c;
   rexp_t       m_r;
   bexp_t       m_b;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [31:0] rdf(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic sync();
      @(posedge ACLK);
      #1;
   endtask

   task automatic clear_sb();
      exp_cmd.delete(); exp_r.delete(); exp_b.delete(); be_q.delete();
      rd_issued = 0; r_popped = 0;
   endtask

   // Backend: drives returns one cycle after the read command is accepted, in issue order.
   always @(posedge ACLK) begin
      #1;
      if (ARESET) begin
         rd_valid  = 1'b0;
         rd_data   = '0;
         cmd_ready = 1'b1;
      end else begin
         cmd_ready = be_toggle ? ~cmd_ready : 1'b1;
         rd_valid  = (be_q.size() > 0);
         rd_data   = rd_valid ? be_q[0] : '0;
      end
   end

   always @(negedge ACLK) begin
      if (!ARESET) begin
         if (S_AWVALID && S_ARVALID) check_val("one_grant", S_AWREADY & S_ARREADY, 0);
         if (S_AWVALID && S_AWREADY) begin glog = {glog[2:0], 1'b1}; n_grants++; end
         if (S_ARVALID && S_ARREADY) begin glog = {glog[2:0], 1'b0}; n_grants++; end
         if (rd_valid) begin
            if (be_q.size() > 0) void'(be_q.pop_front());
            rd_returned++;
         end
         if (cmd_valid) begin
            check_val("cmd_expected", exp_cmd.size() > 0, 1);
            if (cmd_ready && exp_cmd.size() > 0) begin
               m_c = exp_cmd.pop_front();
               check_val("cmd_write", cmd_write, m_c.wr);
               check_val("cmd_addr", cmd_addr, m_c.addr);
               if (m_c.wr) begin
                  check_val("cmd_wdata", cmd_wdata, m_c.data);
                  check_val("cmd_wstrb", cmd_wstrb, m_c.strb);
                  wr_issued++;
                  last_wr_addr = cmd_addr;
               end else begin
                  be_q.push_back(rdf(cmd_addr));
                  rd_issued++;
               end
            end
         end
         if (S_RVALID && S_RREADY) begin
            check_val("r_expected", exp_r.size() > 0, 1);
            if (exp_r.size() > 0) begin
               m_r = exp_r.pop_front();
               check_val("r_beat", {S_RID, S_RDATA, S_RRESP, S_RLAST}, m_r);
               if (m_r.resp == 2'b00) r_popped++;
            end
            r_seen++;
         end
         if (S_BVALID && S_BREADY) begin
            check_val("b_expected", exp_b.size() > 0, 1);
            if (exp_b.size() > 0) begin
               m_b = exp_b.pop_front();
               check_val("b_resp", {S_BID, S_BRESP}, m_b);
            end
            b_seen++;
         end
         occ = rd_issued - r_popped;
         if (occ > max_occ) max_occ = occ;
      end
   end

   task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input int wlast_beat,
                            input logic [31:0] dbase, input logic [3:0] strb);
      int n, tgt;
      bit hs, err;
      err = (burst != 2'b01) || (wlast_beat != int'(len));
      tgt = b_seen + 1;
      S_AWID = id; S_AWADDR = addr; S_AWLEN = len; S_AWBURST = burst; S_AWVALID = 1'b1;
      hs = 0; n = 0;
      while (!hs && n < TMO) begin @(negedge ACLK); hs = S_AWREADY; sync(); n++; end
      check_val("aw_hs", hs, 1);
      S_AWVALID = 1'b0;
      if (burst == 2'b01)
         for (int i = 0; i <= int'(len); i++)
            exp_cmd.push_back('{wr: 1'b1, addr: addr + 32'(4 * i), data: dbase + 32'(i), strb: strb});
      exp_b.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
      for (int i = 0; i <= int'(len); i++) begin
         S_WDATA = dbase + 32'(i); S_WSTRB = strb; S_WLAST = (i == wlast_beat); S_WVALID = 1'b1;
         hs = 0; n = 0;
         while (!hs && n < TMO) begin @(negedge ACLK); hs = S_WREADY; sync(); n++; end
         check_val("w_hs", hs, 1);
      end
      S_WVALID = 1'b0; S_WLAST = 1'b0;
      n = 0;
      while (b_seen < tgt && n < TMO) begin @(posedge ACLK); n++; end
      #1;
      check_val("b_done", b_seen, tgt);
   endtask

   task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input bit wait_r);
      int n, tgt;
      bit hs, err;
      err = (burst != 2'b01);
      tgt = r_seen + int'(len) + 1;
      S_ARID = id; S_ARADDR = addr; S_ARLEN = len; S_ARBURST = burst; S_ARVALID = 1'b1;
      hs = 0; n = 0;
      while (!hs && n < TMO) begin @(negedge ACLK); hs = S_ARREADY; sync(); n++; end
      check_val("ar_hs", hs, 1);
      S_ARVALID = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         if (!err) exp_cmd.push_back('{wr: 1'b0, addr: addr + 32'(4 * i), data: '0, strb: '0});
         exp_r.push_back('{id: id, data: err ? 32'h0 : rdf(addr + 32'(4 * i)),
                           resp: err ? 2'b10 : 2'b00, last: (i == int'(len))});
      end
      if (wait_r) begin
         n = 0;
         while (r_seen < tgt && n < 4 * TMO) begin @(posedge ACLK); n++; end
         #1;
         check_val("r_done", r_seen, tgt);
      end
   endtask

   task automatic do_reset();
      @(posedge ACLK);
      #2;
      ARESET = 1'b1;
      clear_sb();
      repeat (2) @(posedge ACLK);
      #2;
      ARESET = 1'b0;
      sync();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, wr_before;
      ARESET = 1'b1;
      S_AWID = '0; S_AWADDR = '0; S_AWLEN = '0; S_AWBURST = '0; S_AWVALID = 1'b0;
      S_WDATA = '0; S_WSTRB = '0; S_WLAST = 1'b0; S_WVALID = 1'b0; S_BREADY = 1'b1;
      S_ARID = '0; S_ARADDR = '0; S_ARLEN = '0; S_ARBURST = '0; S_ARVALID = 1'b0;
      S_RREADY = 1'b1;
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      check_val("rst_ready", {S_AWREADY, S_ARREADY, S_WREADY}, 0);
      check_val("rst_valid", {S_BVALID, S_RVALID, cmd_valid, S_RLAST}, 0);
      check_val("rst_resp", {S_BRESP, S_RRESP}, 0);
      check_val("rst_rdata", S_RDATA, 0);
      check_val("rst_ids", {S_BID, S_RID}, 0);
      @(posedge ACLK);
      #2;
      ARESET = 1'b0;
      sync();

      // Basic INCR write
      axi_write(4'h5, 32'h100, 4'd3, 2'b01, 3, 32'h1, 4'hF);
      check_val("t1_wr_cnt", wr_issued, 4);

      // Long read with RREADY stalled after beat 2
      max_occ = 0;
      fork
         axi_read(4'h2, 32'h200, 4'd15, 2'b01, 1'b1);
         begin
            n = 0;
            do begin @(posedge ACLK); n++; end while (r_seen < 3 && n < TMO);
            #1;
            S_RREADY = 1'b0;
            repeat (40) @(posedge ACLK);
            @(negedge ACLK);
            check_val("t2_stall_occ", rd_issued - r_popped, 8);
            check_val("t2_stall_issued", rd_issued, 8 + r_popped);
            sync();
            S_RREADY = 1'b1;
         end
      join
      check_val("t2_max_occ", max_occ, 8);
      check_val("t2_rd_cnt", rd_issued, 16);

      // Simultaneous AW/AR from a known priority state
      do_reset();
      glog = '0; n_grants = 0;
      fork
         begin
            axi_write(4'h3, 32'h300, 4'd1, 2'b01, 1, 32'h30, 4'hF);
            axi_write(4'h4, 32'h340, 4'd1, 2'b01, 1, 32'h40, 4'hF);
         end
         begin
            axi_read(4'hA, 32'h380, 4'd1, 2'b01, 1'b1);
            axi_read(4'hB, 32'h3C0, 4'd1, 2'b01, 1'b1);
         end
      join
      check_val("t3_grant_order", glog, 4'b1010);
      check_val("t3_grant_cnt", n_grants, 4);

      // Non-INCR bursts: no backend traffic, SLVERR
      sync();
      wr_before = wr_issued;
      axi_write(4'h6, 32'h400, 4'd1, 2'b10, 1, 32'h50, 4'hF);
      check_val("t4_no_wr", wr_issued, wr_before);
      sync();
      axi_read(4'h9, 32'h480, 4'd1, 2'b00, 1'b1);

      // Early WLAST: writes still issued, SLVERR
      sync();
      wr_before = wr_issued;
      axi_write(4'h7, 32'h500, 4'd3, 2'b01, 1, 32'h60, 4'hF);
      check_val("t5_wr_cnt", wr_issued, wr_before + 4);

      // Reset with three buffered read beats
      sync();
      S_RREADY = 1'b0;
      axi_read(4'hC, 32'h600, 4'd2, 2'b01, 1'b0);
      n = 0;
      while (rd_returned < 3 && n < TMO) begin @(posedge ACLK); n++; end
      repeat (2) @(posedge ACLK);
      #2;
      ARESET = 1'b1;
      clear_sb();
      @(negedge ACLK);
      check_val("t6_rvalid_in_rst", S_RVALID, 0);
      @(posedge ACLK);
      #2;
      ARESET = 1'b0;
      S_RREADY = 1'b1;
      @(negedge ACLK);
      check_val("t6_rvalid_after", S_RVALID, 0);
      check_val("t6_cmd_after", cmd_valid, 0);
      sync();
      axi_read(4'hD, 32'h700, 4'd0, 2'b01, 1'b1);

      // cmd_ready toggling every cycle
      sync();
      be_toggle = 1'b1;
      wr_before = wr_issued;
      axi_write(4'h8, 32'h800, 4'd7, 2'b01, 7, 32'h80, 4'h3);
      be_toggle = 1'b0;
      check_val("t7_wr_cnt", wr_issued, wr_before + 8);

      // Address wrap at the top of the space
      sync();
      axi_write(4'hE, 32'hFFFF_FFFC, 4'd1, 2'b01, 1, 32'h90, 4'hF);
      check_val("t8_wrap_addr", last_wr_addr, 32'h0);

      repeat (3) @(posedge ACLK);
      check_val("end_cmd_q", exp_cmd.size(), 0);
      check_val("end_r_q", exp_r.size(), 0);
      check_val("end_b_q", exp_b.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
